shk_slv_regs: RTL and testbench

Shake-bus slave register bank that sits directly downstream of the command-init shake master. It terminates master transactions (valid/msync/mdata/mdat1/maddr) and returns ready/ssync/sdata/saddr. Decoded writes land in a flat register array consumed by datapath blocks. Read-only status words are returned on reads, and protocol or decode errors are flagged on a sticky error bus.

---
 rtl/shk_slv_regs.sv | 205 ++++++++++++++++++++
 tb/tb_shk_slv_regs.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shk_slv_regs.sv
// ----------------------------------------------------------------------------
// shk_slv_regs
//   Shake-bus slave register bank. Terminates one master transaction at a time
//   through a four-state handshake (IDLE -> EXEC -> RESP -> RELS) and keeps a
//   flat array of RW registers for downstream datapath blocks. RO status words
//   are only ever read. Decode and protocol errors accumulate on a sticky bus.
//
//   Optional feature (compile-time macro):
//     SHK_SLV_WMASK_EN - RW writes are bit-masked by mdat1:
//                        reg <= (reg & ~mdat1) | (mdata & mdat1).
//                        When undefined, mdat1 is ignored and reg <= mdata.
//
//   Ports
//     i_sys_clk, i_sys_resetn      clock, synchronous active-low reset
//     s_shk_cmd_valid/msync/...    master request (msync 1 = write, 0 = read)
//     s_shk_cmd_ready              one-cycle completion pulse
//     s_shk_cmd_ssync/sdata/saddr  ack flag, data, address echo (held)
//     s_reg_sta_arry               RO status words, lowest index in LSBs
//     m_reg_dst_arry               RW register contents, index 0 in LSBs
//     m_reg_dst_updt/indx          pulse + index after an accepted RW write
//     m_err_shk_info               sticky errors:
//                                  [0] miss, [1] write to RO,
//                                  [2] valid dropped mid-transaction,
//                                  [3] at least one error occurred
// ----------------------------------------------------------------------------
module shk_slv_regs #(
   parameter int unsigned                WD_SHK_DATA = 8,
   parameter int unsigned                WD_SHK_ADDR = 16,
   parameter int unsigned                NB_REG_NUMB = 16,
   parameter int unsigned                NB_REG_WRIT = 8,
   parameter logic [WD_SHK_ADDR-1:0]     P_BASE_ADDR = '0,
   parameter int unsigned                WD_ERR_INFO = 4
) (
   input  logic                                       i_sys_clk,
   input  logic                                       i_sys_resetn,
   input  logic                                       s_shk_cmd_valid,
   input  logic                                       s_shk_cmd_msync,
   input  logic [WD_SHK_DATA-1:0]                     s_shk_cmd_mdata,
   input  logic [WD_SHK_DATA-1:0]                     s_shk_cmd_mdat1,
   input  logic [WD_SHK_ADDR-1:0]                     s_shk_cmd_maddr,
   output logic                                       s_shk_cmd_ready,
   output logic                                       s_shk_cmd_ssync,
   output logic [WD_SHK_DATA-1:0]                     s_shk_cmd_sdata,
   output logic [WD_SHK_ADDR-1:0]                     s_shk_cmd_saddr,
   input  logic [WD_SHK_DATA*(NB_REG_NUMB-NB_REG_WRIT)-1:0] s_reg_sta_arry,
   output logic [WD_SHK_DATA*NB_REG_WRIT-1:0]         m_reg_dst_arry,
   output logic                                       m_reg_dst_updt,
   output logic [7:0]                                 m_reg_dst_indx,
   output logic [WD_ERR_INFO-1:0]                     m_err_shk_info
);

   localparam int unsigned NB_REG_RDON = NB_REG_NUMB - NB_REG_WRIT;

   typedef enum logic [1:0] {IDLE, EXEC, RESP, RELS} state_t;

   typedef struct packed {
      logic                   wr;
      logic [WD_SHK_DATA-1:0] data;
      logic [WD_SHK_DATA-1:0] mask;
      logic [WD_SHK_ADDR-1:0] addr;
   } req_t;

   state_t                                 state, state_nxt;
   req_t                                   req;
   logic [WD_SHK_ADDR-1:0]                 req_idx;
   logic                                   req_hit;
   logic [NB_REG_WRIT-1:0][WD_SHK_DATA-1:0] regs;

   // decode of the incoming address, latched together with the request
   logic [WD_SHK_ADDR-1:0]                 in_idx;
   logic                                   in_hit;

   // EXEC-stage results, carried into RESP
   logic                                   res_ack;
   logic [WD_SHK_DATA-1:0]                 res_data;

   logic                                   is_rw;
   logic                                   wr_ok;
   logic                                   exe_ack;
   logic [WD_SHK_DATA-1:0]                 cur_val;
   logic [WD_SHK_DATA-1:0]                 sta_val;
   logic [WD_SHK_DATA-1:0]                 wr_val;
   logic [WD_SHK_DATA-1:0]                 exe_data;
   logic [2:0]                             err_new;

   assign in_idx = s_shk_cmd_maddr - P_BASE_ADDR;
   assign in_hit = (s_shk_cmd_maddr >= P_BASE_ADDR) &&
                   (in_idx < WD_SHK_ADDR'(NB_REG_NUMB));

   assign m_reg_dst_arry = regs;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_resetn) state <= IDLE;
      else               state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (s_shk_cmd_valid) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = RELS;
         RELS:    if (!s_shk_cmd_valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------ EXEC datapath
   always_comb begin
      cur_val = '0;
      for (int i = 0; i < NB_REG_WRIT; i++)
         if (req_idx == WD_SHK_ADDR'(i)) cur_val = regs[i];

      sta_val = '0;
      for (int i = 0; i < NB_REG_RDON; i++)
         if (req_idx == WD_SHK_ADDR'(NB_REG_WRIT + i))
            sta_val = s_reg_sta_arry[i*WD_SHK_DATA +: WD_SHK_DATA];

      is_rw = req_hit && (req_idx < WD_SHK_ADDR'(NB_REG_WRIT));
      wr_ok = req.wr && is_rw;
`ifdef SHK_SLV_WMASK_EN
      wr_val = (cur_val & ~req.mask) | (req.data & req.mask);
`else
      wr_val = req.data;
`endif
      exe_ack = req_hit && (!req.wr || is_rw);

      // every nack returns zero data, whatever the reason
      if (!exe_ack)    exe_data = '0;
      else if (req.wr) exe_data = wr_val;
      else if (is_rw)  exe_data = cur_val;
      else             exe_data = sta_val;

      err_new = '0;
      if (state == EXEC) begin
         err_new[0] = !req_hit;
         err_new[1] = req.wr && req_hit && !is_rw;
         err_new[2] = !s_shk_cmd_valid;
      end else if (state == RESP) begin
         err_new[2] = !s_shk_cmd_valid;
      end
   end

`ifndef SHK_SLV_WMASK_EN
   // mask input has no function without the masked-write feature
   logic unused_mask;
   assign unused_mask = ^req.mask;
`endif

   // ----------------------------------------------------- state / outputs
   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_resetn) begin
         req             <= '0;
         req_idx         <= '0;
         req_hit         <= 1'b0;
         regs            <= '0;
         res_ack         <= 1'b0;
         res_data        <= '0;
         s_shk_cmd_ready <= 1'b0;
         s_shk_cmd_ssync <= 1'b0;
         s_shk_cmd_sdata <= '0;
         s_shk_cmd_saddr <= '0;
         m_reg_dst_updt  <= 1'b0;
         m_reg_dst_indx  <= '0;
         m_err_shk_info  <= '0;
      end else begin
         s_shk_cmd_ready <= 1'b0;
         m_reg_dst_updt  <= 1'b0;

         // err[3] rides along with any newly flagged error
         if (|err_new)
            m_err_shk_info <= m_err_shk_info | {1'b1, err_new};

         case (state)
            IDLE: if (s_shk_cmd_valid) begin
               req.wr   <= s_shk_cmd_msync;
               req.data <= s_shk_cmd_mdata;
               req.mask <= s_shk_cmd_mdat1;
               req.addr <= s_shk_cmd_maddr;
               req_idx  <= in_idx;
               req_hit  <= in_hit;
            end
            EXEC: begin
               for (int i = 0; i < NB_REG_WRIT; i++)
                  if (wr_ok && req_idx == WD_SHK_ADDR'(i)) regs[i] <= wr_val;
               res_ack  <= exe_ack;
               res_data <= exe_data;
            end
            RESP: begin
               s_shk_cmd_ready <= 1'b1;
               s_shk_cmd_ssync <= res_ack;
               s_shk_cmd_sdata <= res_data;
               s_shk_cmd_saddr <= req.addr;
               if (req.wr && res_ack) begin
                  m_reg_dst_updt <= 1'b1;
                  m_reg_dst_indx <= req_idx[7:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shk_slv_regs.sv
module tb_shk_slv_regs;

   localparam logic [15:0] BASE = 16'h0100;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid = 1'b0, msync = 1'b0;
   logic [7:0]  mdata = '0, mdat1 = '0;
   logic [15:0] maddr = '0;
   logic [63:0] sta = '0;

   logic        ready, ssync, updt;
   logic [7:0]  sdata, indx;
   logic [15:0] saddr;
   logic [63:0] arry;
   logic [3:0]  err;

   always #5 clk = ~clk;

   shk_slv_regs #(.P_BASE_ADDR(BASE)) dut (
      .i_sys_clk(clk), .i_sys_resetn(resetn),
      .s_shk_cmd_valid(valid), .s_shk_cmd_msync(msync),
      .s_shk_cmd_mdata(mdata), .s_shk_cmd_mdat1(mdat1), .s_shk_cmd_maddr(maddr),
      .s_shk_cmd_ready(ready), .s_shk_cmd_ssync(ssync),
      .s_shk_cmd_sdata(sdata), .s_shk_cmd_saddr(saddr),
      .s_reg_sta_arry(sta), .m_reg_dst_arry(arry),
      .m_reg_dst_updt(updt), .m_reg_dst_indx(indx), .m_err_shk_info(err));

   // ---------------------------------------------------------------- model
   logic [7:0]  exp_regs [8];
   logic [3:0]  exp_err;
   logic        exp_ready, exp_ssync, exp_updt;
   logic [7:0]  exp_sdata, exp_indx;
   logic [15:0] exp_saddr;
   logic        pend_ack, pend_updt;
   logic [7:0]  pend_data, pend_indx;
   logic [15:0] pend_addr;

   int n_chk = 0, n_fail = 0;
   int cyc = 0, start_cyc = 0, rdy_cyc = 0, n_ready = 0, n_updt = 0;
   logic        cap_ssync, cap_updt;
   logic [7:0]  cap_sdata, cap_indx;
   logic [15:0] cap_saddr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (exp_regs[i]) exp_regs[i] = '0;
      exp_err = '0; exp_ready = 0; exp_ssync = 0; exp_updt = 0;
      exp_sdata = '0; exp_indx = '0; exp_saddr = '0;
   endtask

   task automatic add_err(input logic [2:0] b);
      if (b != 0) exp_err = exp_err | {1'b1, b};
   endtask

   // Transaction-level effect of one request, applied at its EXEC edge
   task automatic model_exec(input bit wr, input logic [15:0] addr,
                             input logic [7:0] d, input logic [7:0] m, input bit dropped);
      logic [15:0] idx;
      bit hit, rw;
      logic [7:0] nv;
      idx = addr - BASE;
      hit = (addr >= BASE) && (idx < 16);
      rw  = hit && (idx < 8);
      pend_addr = addr; pend_updt = 0; pend_indx = idx[7:0];
      pend_ack = hit && (!wr || rw);
      pend_data = 8'h00;
      if (wr && rw) begin
`ifdef SHK_SLV_WMASK_EN
         nv = (exp_regs[idx[2:0]] & ~m) | (d & m);
`else
         nv = d;
`endif
         exp_regs[idx[2:0]] = nv;
         pend_data = nv; pend_updt = 1;
      end else if (!wr && rw) pend_data = exp_regs[idx[2:0]];
      else if (!wr && hit)    pend_data = sta[(idx-8)*8 +: 8];
      add_err({dropped, wr && hit && !rw, !hit});
   endtask

   task automatic model_resp(input bit dropped);
      exp_ready = 1; exp_ssync = pend_ack; exp_sdata = pend_data;
      exp_saddr = pend_addr; exp_updt = pend_updt;
      if (pend_updt) exp_indx = pend_indx;
      add_err({dropped, 2'b00});
   endtask

   // ------------------------------------------------------ compare process
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      chk("ready", ready, exp_ready);
      chk("ssync", ssync, exp_ssync);
      chk("sdata", sdata, exp_sdata);
      chk("saddr", saddr, exp_saddr);
      chk("updt",  updt,  exp_updt);
      chk("err",   err,   exp_err);
      for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), arry[i*8 +: 8], exp_regs[i]);
      if (exp_updt) chk("indx", indx, exp_indx);
      if (ready) begin
         n_ready++; rdy_cyc = cyc;
         cap_ssync = ssync; cap_sdata = sdata; cap_saddr = saddr;
         cap_updt = updt; cap_indx = indx;
      end
      if (updt) n_updt++;
   end

   // -------------------------------------------------------------- driver
   task automatic scramble();
      msync = 1'($urandom); mdata = 8'($urandom);
      mdat1 = 8'($urandom); maddr = 16'($urandom);
   endtask

   // drop: 0 none, 1 valid low at EXEC edge, 2 valid low at RESP edge
   // hold: extra cycles valid stays high after the ready pulse
   task automatic txn(input bit wr, input logic [15:0] addr, input logic [7:0] d,
                      input logic [7:0] m, input int drop, input int hold);
      @(negedge clk);
      valid = 1; msync = wr; maddr = addr; mdata = d; mdat1 = m;
      @(posedge clk); #1 start_cyc = cyc;
      @(negedge clk); if (drop == 1) valid = 0; else scramble();
      @(posedge clk); #1 model_exec(wr, addr, d, m, drop == 1);
      @(negedge clk); if (drop == 2) valid = 0; else if (drop == 0) scramble();
      @(posedge clk); #1 model_resp(drop == 2);
      @(negedge clk); if (drop == 0) begin if (hold == 0) valid = 0; else scramble(); end
      @(posedge clk); #1 exp_ready = 0; exp_updt = 0;
      if (drop == 0)
         for (int h = 1; h <= hold; h++) begin
            @(negedge clk); if (h == hold) valid = 0; else scramble();
            @(posedge clk);
         end
   endtask

   initial begin
      int r0, u0;
      model_reset();
      sta = 64'h7766_5544_333C_2211;   // word 2 (idx 10) = 3C
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arry", arry, 64'h0);
      chk("rst_err",  err,  4'h0);
      chk("rst_indx", indx, 8'h0);
      resetn = 1;

      // basic write
      txn(1, BASE + 3, 8'hA5, 8'hFF, 0, 0);
      chk("wr_latency", rdy_cyc - start_cyc, 2);
      chk("wr_ssync", cap_ssync, 1'b1);
      chk("wr_sdata", cap_sdata, 8'hA5);
      chk("wr_saddr", cap_saddr, BASE + 3);
      chk("wr_updt",  cap_updt, 1'b1);
      chk("wr_indx",  cap_indx, 8'd3);
      chk("wr_reg3",  arry[31:24], 8'hA5);

      // RO read
      txn(0, BASE + 10, 8'h00, 8'h00, 0, 0);
      chk("rd_ssync", cap_ssync, 1'b1);
      chk("rd_sdata", cap_sdata, 8'h3C);
      chk("rd_updt",  cap_updt, 1'b0);

      // miss, then RO write
      txn(1, BASE + 16, 8'h55, 8'hFF, 0, 0);
      chk("miss_ssync", cap_ssync, 1'b0);
      chk("miss_sdata", cap_sdata, 8'h00);
      chk("miss_err",   err, 4'b1001);
      txn(1, BASE + 9, 8'h66, 8'hFF, 0, 0);
      chk("ro_ssync", cap_ssync, 1'b0);
      chk("ro_err",   err, 4'b1011);

      // drop valid during EXEC
      r0 = n_ready;
      txn(1, BASE + 5, 8'h5A, 8'hFF, 1, 0);
      chk("drop_ready", n_ready - r0, 1);
      chk("drop_reg5",  arry[47:40], 8'h5A);
      chk("drop_err",   err, 4'b1111);

      // long hold after ready: exactly one transaction
      r0 = n_ready;
      txn(1, BASE + 6, 8'h11, 8'hFF, 0, 5);
      chk("hold_ready", n_ready - r0, 1);

      // masked write
      txn(1, BASE + 1, 8'hF0, 8'hFF, 0, 0);
      txn(1, BASE + 1, 8'h0F, 8'h3C, 0, 0);
`ifdef SHK_SLV_WMASK_EN
      chk("mask_reg1", arry[15:8], 8'hCC);
`else
      chk("mask_reg1", arry[15:8], 8'h0F);
`endif

      // back-to-back writes to one register
      u0 = n_updt;
      txn(1, BASE + 2, 8'h12, 8'hFF, 0, 0);
      txn(1, BASE + 2, 8'h34, 8'hFF, 0, 0);
      chk("b2b_updt", n_updt - u0, 2);
      chk("b2b_reg2", arry[23:16], 8'h34);

      // randomized traffic
      for (int k = 0; k < 80; k++) begin
         int dr;
         logic [15:0] a;
         @(negedge clk);
         sta = {$urandom, $urandom};
         dr = $urandom_range(0, 9);
         a  = (k % 17 == 0) ? 16'($urandom) : BASE - 16'd4 + 16'($urandom_range(0, 23));
         txn(1'($urandom), a, 8'($urandom), 8'($urandom),
             (dr < 7) ? 0 : dr - 7, $urandom_range(0, 3));
      end

      // reset while in RESP
      @(negedge clk);
      valid = 1; msync = 1; maddr = BASE + 4; mdata = 8'h77; mdat1 = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk); #1 model_exec(1, BASE + 4, 8'h77, 8'hFF, 0);
      @(negedge clk); resetn = 0; valid = 0;
      @(posedge clk); #1 model_reset();
      @(negedge clk);
      chk("rstr_arry",  arry,  64'h0);
      chk("rstr_ready", ready, 1'b0);
      chk("rstr_sdata", sdata, 8'h00);
      resetn = 1;
      txn(1, BASE + 7, 8'hC3, 8'hFF, 0, 0);
      chk("post_ssync", cap_ssync, 1'b1);
      chk("post_reg7",  arry[63:56], 8'hC3);
      chk("post_err",   err, 4'h0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
